// File: rtl/mips_ctrl_pkg.sv
// Shared types and constants for the mips_np program-load/run sequencer.
package mips_ctrl_pkg;

  localparam int WORD_BYTES     = 4;
  localparam int DEF_DATA_W     = 32;
  localparam int DEF_ADDR_W     = 32;
  localparam int DEF_IMEM_WORDS = 256;
  localparam int DEF_CYC_W      = 16;

  typedef enum logic [2:0] {IDLE, LOAD, RUN, DUMP, DONE} run_state_t;

  // Per-word readback steps: present address, capture memory data, hold result until taken.
  typedef enum logic [1:0] {DP_ADDR, DP_CAP, DP_HOLD} dump_phase_t;

endpackage

// File: rtl/mips_np_run_ctrl_if.sv
// Host/core-facing signal bundle of the run sequencer.
// slave: the sequencer's view; master: the host/bench view.
interface mips_np_run_ctrl_if
  import mips_ctrl_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int CYC_W  = DEF_CYC_W
);
  logic              start_in;
  logic [CYC_W-1:0]  run_cycles_in;
  logic [ADDR_W-1:0] dump_base_in;
  logic [7:0]        dump_words_in;
  logic              prog_valid_in;
  logic [DATA_W-1:0] prog_data_in;
  logic              prog_last_in;
  logic              prog_ready_out;
  logic              cpu_reset_out;
  logic              instr_write_out;
  logic [ADDR_W-1:0] instr_address_out;
  logic [DATA_W-1:0] instr_out;
  logic [ADDR_W-1:0] read_data_address_out;
  logic [DATA_W-1:0] read_data_in;
  logic              res_valid_out;
  logic [DATA_W-1:0] res_data_out;
  logic              res_ready_in;
  logic              busy_out;
  logic              done_out;
  logic              overflow_out;

  modport slave (
    input  start_in, run_cycles_in, dump_base_in, dump_words_in,
           prog_valid_in, prog_data_in, prog_last_in, read_data_in, res_ready_in,
    output prog_ready_out, cpu_reset_out, instr_write_out, instr_address_out, instr_out,
           read_data_address_out, res_valid_out, res_data_out, busy_out, done_out, overflow_out
  );

  modport master (
    output start_in, run_cycles_in, dump_base_in, dump_words_in,
           prog_valid_in, prog_data_in, prog_last_in, read_data_in, res_ready_in,
    input  prog_ready_out, cpu_reset_out, instr_write_out, instr_address_out, instr_out,
           read_data_address_out, res_valid_out, res_data_out, busy_out, done_out, overflow_out
  );
endinterface

// File: rtl/mips_np_run_ctrl.sv
// Program-load and run sequencer for mips_np: streams a program into instruction
// memory, releases the core for a fixed cycle budget, then reads back a data window.
module mips_np_run_ctrl
  import mips_ctrl_pkg::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int IMEM_WORDS = DEF_IMEM_WORDS,
  parameter int CYC_W      = DEF_CYC_W
) (
  input logic               clock_in,
  input logic               reset_in,
  mips_np_run_ctrl_if.slave bus
);

  run_state_t        state;
  dump_phase_t       phase;
  logic [CYC_W-1:0]  run_budget;
  logic [CYC_W-1:0]  cyc_left;
  logic [ADDR_W-1:0] dump_base;
  logic [7:0]        dump_count;
  logic [7:0]        dump_left;
  logic [ADDR_W-1:0] load_idx;
  logic              last_taken;

  function automatic logic [ADDR_W-1:0] word_addr(input logic [ADDR_W-1:0] idx);
    return idx * ADDR_W'(WORD_BYTES);
  endfunction

  // Sequencer FSM with all outputs registered; the three counters live alongside it.
  always_ff @(posedge clock_in) begin
    if (!reset_in) begin
      state                     <= IDLE;
      phase                     <= DP_ADDR;
      last_taken                <= 1'b0;
      bus.prog_ready_out        <= 1'b0;
      bus.cpu_reset_out         <= 1'b0;
      bus.instr_write_out       <= 1'b0;
      bus.instr_address_out     <= '0;
      bus.instr_out             <= '0;
      bus.read_data_address_out <= '0;
      bus.res_valid_out         <= 1'b0;
      bus.res_data_out          <= '0;
      bus.busy_out              <= 1'b0;
      bus.done_out              <= 1'b0;
      bus.overflow_out          <= 1'b0;
    end else begin
      bus.instr_write_out <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (bus.start_in) begin
            state              <= LOAD;
            run_budget         <= bus.run_cycles_in;
            dump_base          <= bus.dump_base_in;
            dump_count         <= bus.dump_words_in;
            load_idx           <= '0;
            last_taken         <= 1'b0;
            bus.prog_ready_out <= 1'b1;
            bus.busy_out       <= 1'b1;
            bus.done_out       <= 1'b0;
          end
        end
        LOAD: begin
          // The final write pulse is on the bus this cycle; release the core next.
          if (last_taken) begin
            state             <= RUN;
            cyc_left          <= run_budget;
            bus.cpu_reset_out <= (run_budget != '0);
          end else if (bus.prog_valid_in && bus.prog_ready_out) begin
            load_idx <= load_idx + ADDR_W'(1);
            if (load_idx < ADDR_W'(IMEM_WORDS)) begin
              bus.instr_write_out   <= 1'b1;
              bus.instr_out         <= DATA_W'(bus.prog_data_in);
              bus.instr_address_out <= word_addr(load_idx);
            end else begin
              bus.overflow_out <= 1'b1;
            end
            if (bus.prog_last_in) begin
              last_taken         <= 1'b1;
              bus.prog_ready_out <= 1'b0;
            end
          end
        end
        RUN: begin
          // cyc_left counts the remaining high cycles including the current one.
          if (cyc_left <= CYC_W'(1)) begin
            state                     <= DUMP;
            phase                     <= DP_ADDR;
            bus.cpu_reset_out         <= 1'b0;
            bus.read_data_address_out <= dump_base;
            dump_left                 <= dump_count;
          end else begin
            cyc_left <= cyc_left - CYC_W'(1);
          end
        end
        DUMP: begin
          case (phase)
            DP_ADDR: begin
              if (dump_left == 8'd0) begin
                state        <= DONE;
                bus.busy_out <= 1'b0;
                bus.done_out <= 1'b1;
              end else begin
                phase <= DP_CAP;
              end
            end
            DP_CAP: begin
              bus.res_data_out  <= DATA_W'(bus.read_data_in);
              bus.res_valid_out <= 1'b1;
              phase             <= DP_HOLD;
            end
            default: begin
              if (bus.res_ready_in) begin
                bus.res_valid_out         <= 1'b0;
                dump_left                 <= dump_left - 8'd1;
                bus.read_data_address_out <= bus.read_data_address_out + ADDR_W'(WORD_BYTES);
                phase                     <= DP_ADDR;
              end
            end
          endcase
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_np_run_ctrl.sv
// Randomized scoreboard bench for mips_np_run_ctrl with a small instruction memory.
module tb_mips_np_run_ctrl;
  import mips_ctrl_pkg::*;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 32;
  localparam int CYC_W  = 16;
  localparam int IMEM_W = 4;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } item_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mips_np_run_ctrl_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CYC_W(CYC_W)) bus ();

  mips_np_run_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .IMEM_WORDS(IMEM_W), .CYC_W(CYC_W)) dut (
    .clock_in(clk),
    .reset_in(rst_n),
    .bus(bus)
  );

  int tests = 0;
  int fails = 0;
  item_t wr_q[$];
  item_t res_q[$];
  logic [31:0] prog_words[$];
  bit exp_ovf = 0;
  int hi_cnt = 0;
  int res_seen = 0;
  int stall_cnt = 0;
  int rdy_mode = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] dmem(input logic [31:0] a);
    return {a[15:0] ^ 16'h5A5A, a[31:16] + 16'h1234};
  endfunction

  // Data memory model: synchronous read, data one cycle after the address.
  always @(posedge clk) bus.read_data_in <= dmem(bus.read_data_address_out);

  // Instruction write monitor.
  item_t we;
  always @(negedge clk) begin
    if (rst_n && bus.instr_write_out) begin
      if (wr_q.size() == 0) check("unexpected_write", 1, 0);
      else begin
        we = wr_q.pop_front();
        check("wr_addr", bus.instr_address_out, we.addr);
        check("wr_data", bus.instr_out, we.data);
      end
    end
  end

  // Result monitor, including stability while the consumer stalls.
  item_t re;
  bit hold_prev = 0;
  logic [31:0] hold_data, hold_addr;
  always @(negedge clk) begin
    if (!rst_n) hold_prev = 0;
    else begin
      if (hold_prev) begin
        check("stall_valid", bus.res_valid_out, 1);
        check("stall_data", bus.res_data_out, hold_data);
        check("stall_addr", bus.read_data_address_out, hold_addr);
      end
      if (bus.res_valid_out && bus.res_ready_in) begin
        hold_prev = 0;
        if (res_q.size() == 0) check("unexpected_result", 1, 0);
        else begin
          re = res_q.pop_front();
          check("res_addr", bus.read_data_address_out, re.addr);
          check("res_data", bus.res_data_out, re.data);
        end
        res_seen++;
      end else if (bus.res_valid_out) begin
        hold_prev = 1;
        hold_data = bus.res_data_out;
        hold_addr = bus.read_data_address_out;
      end else hold_prev = 0;
    end
  end

  // Core-release cycle counter.
  always @(negedge clk) if (bus.cpu_reset_out) hi_cnt++;

  // Result consumer: always ready, random, or a 5-cycle stall on result word 1.
  initial begin
    bus.res_ready_in = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0: bus.res_ready_in = 1'b1;
        1: bus.res_ready_in = 1'($urandom_range(0, 1));
        default: begin
          if (bus.res_valid_out && res_seen == 1 && stall_cnt < 5) begin
            bus.res_ready_in = 1'b0;
            stall_cnt++;
          end else bus.res_ready_in = 1'b1;
        end
      endcase
    end
  end

  task automatic check_idle_outputs(input string tag);
    check({tag, "_cpu_reset"}, bus.cpu_reset_out, 0);
    check({tag, "_instr_write"}, bus.instr_write_out, 0);
    check({tag, "_prog_ready"}, bus.prog_ready_out, 0);
    check({tag, "_res_valid"}, bus.res_valid_out, 0);
    check({tag, "_busy"}, bus.busy_out, 0);
    check({tag, "_done"}, bus.done_out, 0);
    check({tag, "_overflow"}, bus.overflow_out, 0);
  endtask

  // One full program/run/dump job; abort_at>0 asserts reset in that RUN cycle instead.
  task automatic run_job(input int budget, input logic [31:0] base, input int nd,
                         input int mode, input int abort_at);
    int nw;
    int guard;
    int c;
    bit acc;
    logic [31:0] a;
    nw = prog_words.size();
    for (int i = 0; i < nw; i++)
      if (i < IMEM_W) wr_q.push_back('{addr: 32'(4 * i), data: prog_words[i]});
    if (nw > IMEM_W) exp_ovf = 1;
    for (int k = 0; k < nd; k++) begin
      a = base + 32'(4 * k);
      res_q.push_back('{addr: a, data: dmem(a)});
    end
    rdy_mode = mode; res_seen = 0; stall_cnt = 0; hi_cnt = 0;

    @(posedge clk); #1;
    bus.start_in = 1'b1;
    bus.run_cycles_in = 16'(budget);
    bus.dump_base_in = base;
    bus.dump_words_in = 8'(nd);
    @(posedge clk); #1;
    bus.start_in = 1'b0;
    bus.run_cycles_in = 16'($urandom);
    bus.dump_base_in = $urandom;
    bus.dump_words_in = 8'($urandom);

    for (int i = 0; i < nw; i++) begin
      if ($urandom_range(0, 2) == 0) begin @(posedge clk); #1; end
      if (i == 1) begin
        bus.start_in = 1'b1;
        @(posedge clk); #1;
        bus.start_in = 1'b0;
      end
      bus.prog_valid_in = 1'b1;
      bus.prog_data_in = prog_words[i];
      bus.prog_last_in = (i == nw - 1);
      guard = 0;
      do begin
        @(negedge clk);
        acc = bus.prog_ready_out;
        @(posedge clk); #1;
        guard++;
      end while (!acc && guard < 50);
      if (!acc) check("load_timeout", 0, 1);
      bus.prog_valid_in = 1'b0;
      bus.prog_last_in = 1'b0;
    end

    if (abort_at > 0) begin
      c = 0; guard = 0;
      while (c < abort_at && guard < 500) begin
        @(negedge clk);
        if (bus.cpu_reset_out) c++;
        guard++;
      end
      check("abort_reach", c, abort_at);
      rst_n = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check_idle_outputs("mid_reset");
      res_q.delete();
      wr_q.delete();
      exp_ovf = 0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      return;
    end

    guard = 0;
    while (!bus.done_out && guard < 3000) begin
      @(negedge clk);
      guard++;
    end
    check("done_reached", bus.done_out, 1);
    @(negedge clk);
    check("done_hold", bus.done_out, 1);
    check("busy_at_done", bus.busy_out, 0);
    check("cpu_reset_at_done", bus.cpu_reset_out, 0);
    check("ready_at_done", bus.prog_ready_out, 0);
    check("overflow", bus.overflow_out, exp_ovf);
    check("run_cycles", hi_cnt, budget);
    check("writes_left", wr_q.size(), 0);
    check("results_left", res_q.size(), 0);
    if (mode == 2 && nd > 1) check("stall_len", stall_cnt, 5);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.start_in = 1'b0;
    bus.run_cycles_in = '0;
    bus.dump_base_in = '0;
    bus.dump_words_in = '0;
    bus.prog_valid_in = 1'b0;
    bus.prog_data_in = '0;
    bus.prog_last_in = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_idle_outputs("reset");
    check("reset_instr_addr", bus.instr_address_out, 0);
    check("reset_instr", bus.instr_out, 0);
    check("reset_rd_addr", bus.read_data_address_out, 0);
    check("reset_res_data", bus.res_data_out, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Program words offered while idle are not taken.
    bus.prog_valid_in = 1'b1;
    bus.prog_data_in = 32'hDEADBEEF;
    bus.prog_last_in = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("idle_ready", bus.prog_ready_out, 0);
    end
    @(posedge clk); #1;
    bus.prog_valid_in = 1'b0;
    bus.prog_last_in = 1'b0;

    prog_words = '{32'h20080005, 32'h20090003, 32'h01095020};
    run_job(10, 32'h10, 4, 0, 0);

    prog_words = '{$urandom, $urandom};
    run_job(3, 32'h100, 3, 2, 0);

    prog_words = '{$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    run_job(5, 32'h0, 2, 1, 0);

    prog_words = '{$urandom};
    run_job(0, 32'h40, 0, 0, 0);

    prog_words = '{$urandom, $urandom};
    run_job(10, 32'h20, 2, 0, 3);

    prog_words = '{$urandom, $urandom, $urandom};
    run_job(4, 32'hFFFF_FFF8, 4, 1, 0);

    for (int j = 0; j < 12; j++) begin
      int nw;
      logic [31:0] base;
      nw = $urandom_range(1, 6);
      prog_words.delete();
      for (int i = 0; i < nw; i++) prog_words.push_back($urandom);
      base = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 : ($urandom & 32'hFFFF_FFFC);
      run_job($urandom_range(0, 8), base, $urandom_range(0, 5), $urandom_range(0, 2), 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
